mem_port_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 32-bit memory port among four requesters (e.g. fetch, load/store, debug, DMA).
- Drives the 2-bit select of the existing 4:1 32-bit data/address mux.
- Sequences one transaction at a time: grant, hold until the memory acknowledges, then rotate priority.
- Sits between the pipeline request sources and the memory interface.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_rr_priority_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Four requesters share one 32-bit memory port.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  typedef logic [NUM_REQ-1:0]   req_vec_t;

  function automatic req_vec_t onehot(
    input req_idx_t idx
  );
    onehot = req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: first request after
// last_grant, wrapping modulo NUM_REQ.
module rr_priority_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] last_grant,
  output logic [REQ_IDX_W-1:0] winner,
  output logic                 any_req
);

  logic [REQ_IDX_W-1:0] idx;
  logic                 found;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_grant + REQ_IDX_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the shared memory port:
// grant, hold until mem_ready or timeout, rotate.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 mem_ready,
  output logic [REQ_IDX_W-1:0] sel,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 mem_valid,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REQ_IDX_W-1:0] sel_q, sel_d;
  logic [REQ_IDX_W-1:0] last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic [REQ_IDX_W-1:0] winner;
  logic                 any_req;

  rr_priority_pick u_pick (
    .req        (req),
    .last_grant (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (any_req) begin
          sel_d   = winner;
          grant_d = onehot(winner);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          ack_d[sel_q] = 1'b1;
          last_d       = sel_q;
          grant_d      = '0;
          state_d      = IDLE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          err_d[sel_q] = 1'b1;
          last_d       = sel_q;
          grant_d      = '0;
          state_d      = IDLE;
        end else if (cnt_q != '1) begin
          // saturate so a disabled timeout never wraps
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= REQ_IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign mem_valid = (state_q == BUSY);
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs driven and outputs sampled on negedge.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       mem_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       mem_valid;
  logic [3:0] ack;
  logic [3:0] err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .mem_ready (mem_ready),
    .sel       (sel),
    .grant     (grant),
    .mem_valid (mem_valid),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (sel !== 2'd0 || grant !== 4'b0 ||
        mem_valid !== 1'b0 || busy !== 1'b0 ||
        ack !== 4'b0 || err !== 4'b0) begin
      bad++;
      $display("FAIL reset: sel=%0d grant=%b mv=%b busy=%b ack=%b err=%b",
               sel, grant, mem_valid, busy, ack, err);
    end
  endtask

  task automatic test_single();
    int mv = 0;
    int acks = 0;
    req = 4'b0001;
    tick();
    total++;
    if (sel !== 2'd0 || grant !== 4'b0001 || mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: sel=%0d grant=%b mv=%b want 0 0001 1",
               sel, grant, mem_valid);
    end
    for (int i = 0; i < 20; i++) begin
      if (ack != 4'b0) break;
      if (mem_valid) mv++;
      if (mv == 3) mem_ready = 1'b1;
      tick();
    end
    total++;
    if (mv !== 3) begin
      bad++;
      $display("FAIL single_mv_len: got %0d want 3", mv);
    end
    total++;
    if (ack !== 4'b0001 || grant !== 4'b0 || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_ack: ack=%b grant=%b mv=%b want 0001 0000 0",
               ack, grant, mem_valid);
    end
    req = '0; mem_ready = 1'b0;
    tick();
    total++;
    if (ack !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse: ack=%b busy=%b want 0000 0", ack, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      total++;
      if (sel !== 2'(k % 4) || grant !== oh || mem_valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_grant%0d: sel=%0d grant=%b want %0d %b",
                 k, sel, grant, k % 4, oh);
      end
      tick();
      total++;
      if (ack !== oh || grant !== 4'b0 || mem_valid !== 1'b0) begin
        bad++;
        $display("FAIL rr_ack%0d: ack=%b grant=%b mv=%b want %b 0000 0",
                 k, ack, grant, mem_valid, oh);
      end
    end
    req = '0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    req = 4'b0010; mem_ready = 1'b1;
    tick();
    total++;
    if (sel !== 2'd1) begin
      bad++;
      $display("FAIL prio_setup: sel=%0d want 1", sel);
    end
    tick();
    req = 4'b0011;
    tick();
    total++;
    if (sel !== 2'd0 || grant !== 4'b0001) begin
      bad++;
      $display("FAIL prio_wrap: sel=%0d grant=%b want 0 0001", sel, grant);
    end
    tick();
    req = 4'b0010;
    tick();
    total++;
    if (sel !== 2'd1 || grant !== 4'b0010) begin
      bad++;
      $display("FAIL prio_next: sel=%0d grant=%b want 1 0010", sel, grant);
    end
    tick();
    req = '0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int mv = 0;
    bit saw_ack = 0;
    req = 4'b0100; mem_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack != 4'b0) saw_ack = 1;
      if (err != 4'b0) break;
      if (mem_valid) mv++;
    end
    total++;
    if (mv !== 16) begin
      bad++;
      $display("FAIL to_len: mv cycles %0d want 16", mv);
    end
    total++;
    if (err !== 4'b0100 || saw_ack || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_err: err=%b ack_seen=%0d mv=%b want 0100 0 0",
               err, saw_ack, mem_valid);
    end
    req = 4'b1001;
    tick();
    total++;
    if (sel !== 2'd3 || grant !== 4'b1000 || err !== 4'b0) begin
      bad++;
      $display("FAIL to_rotate: sel=%0d grant=%b err=%b want 3 1000 0000",
               sel, grant, err);
    end
    mem_ready = 1'b1;
    tick();
    req = '0; mem_ready = 1'b0;
    total++;
    if (ack !== 4'b1000) begin
      bad++;
      $display("FAIL to_ack3: ack=%b want 1000", ack);
    end
    tick(); tick();
    total++;
    if (sel !== 2'd3 || grant !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: sel=%0d grant=%b busy=%b want 3 0000 0",
               sel, grant, busy);
    end
  endtask

  task automatic test_ready_on_timeout();
    int mv = 0;
    req = 4'b0001; mem_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((ack | err) != 4'b0) break;
      if (mem_valid) mv++;
      if (mv == 16) mem_ready = 1'b1;
    end
    total++;
    if (ack !== 4'b0001 || err !== 4'b0 || mv !== 16) begin
      bad++;
      $display("FAIL ready_vs_to: ack=%b err=%b mv=%0d want 0001 0000 16",
               ack, err, mv);
    end
    req = '0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    tick();
    total++;
    if (sel !== 2'd3 || mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_grant: sel=%0d mv=%b want 3 1", sel, mem_valid);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if (mem_valid !== 1'b0 || grant !== 4'b0 || sel !== 2'd0 ||
        ack !== 4'b0 || err !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: mv=%b grant=%b sel=%0d ack=%b err=%b",
               mem_valid, grant, sel, ack, err);
    end
    reset = 1'b0; req = 4'b1001;
    tick();
    total++;
    if (sel !== 2'd0 || grant !== 4'b0001) begin
      bad++;
      $display("FAIL mid_prio: sel=%0d grant=%b want 0 0001", sel, grant);
    end
    mem_ready = 1'b1;
    tick();
    req = 4'b1000;
    tick();
    total++;
    if (sel !== 2'd3 || grant !== 4'b1000) begin
      bad++;
      $display("FAIL mid_next: sel=%0d grant=%b want 3 1000", sel, grant);
    end
    tick();
    req = '0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
